phys_reg_file_mp: RTL
=====================

Name: phys_reg_file_mp

Overview:
- Multi-ported, parametrised physical register file for the register-renaming back end.
- Adds per-register ready (scoreboard) bits on top of plain storage:
  - rename allocation clears a register's ready bit;
  - writeback sets it;
  - a flush sets all ready bits.
- Sits between the rename/free-list stage (allocation) and the issue/execute stages (operand reads, writebacks).

Parameters:
- DATA_W, 32: data width of each physical register.
- NUM_PREGS, 64: number of physical registers; power of two, at least 2.
- PREG_W, 6: physical register index width, log2(NUM_PREGS).
- NUM_RD, 4: number of read ports.
- NUM_WR, 2: number of write (writeback) ports.
- NUM_AL, 2: number of allocation ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  NUM_WR  per-port write enable.
- wr_preg  input  NUM_WR*PREG_W  write indices; port k occupies bits [k*PREG_W +: PREG_W].
- wr_data  input  NUM_WR*DATA_W  write data, packed the same way.
- al_en  input  NUM_AL  per-port allocation enable.
- al_preg  input  NUM_AL*PREG_W  newly allocated destination pregs.
- flush  input  1  pipeline flush; sets every ready bit.
- rd_preg  input  NUM_RD*PREG_W  read indices.
- rd_data  output  NUM_RD*DATA_W  read data; combinational.
- rd_ready  output  NUM_RD  ready bit of each addressed preg; combinational.
- num_busy  output  PREG_W+1  registered count of pregs whose ready bit is 0.

Behaviour:
Reset (reset=0, asynchronous):
- All data entries clear to 0.
- All ready bits set to 1.
- num_busy = 0.
- Reset asserted mid-operation discards any in-flight writes or allocations immediately.
- Outputs reflect the cleared state once reset is low: rd_data=0, rd_ready=1.

Preg 0:
- Hardwired to zero and always ready.
- Writes to it are ignored; allocations to it are ignored.

Write (per port k, wr_en[k]=1, wr_preg!=0):
- At the clock edge, data[wr_preg] <= wr_data and ready[wr_preg] <= 1.

Allocate (per port j, al_en[j]=1, al_preg!=0):
- At the clock edge, ready[al_preg] <= 0.
- Data is unchanged.

Flush:
- At the clock edge, all ready bits <= 1; data is unchanged.
- Flush overrides allocation in the same cycle.
- Writes in the same cycle still update data.

Priority for the same preg in the same cycle:
- Data: among simultaneous writes, the highest-numbered write port wins.
- Ready bit: flush > allocate > write, i.e. allocate plus write leaves ready=0 with the new data stored.
- Duplicate allocations to one preg count once.

num_busy:
- Registered; equals the population count of cleared ready bits after each edge.
- Range 0..NUM_PREGS-1.

Read latency:
- 0 cycles (combinational from rd_preg and the array).
- Reads of preg 0 return data 0 and ready 1.

No handshake: the producer guarantees legal indices; out-of-range indices cannot occur because of power-of-two sizing.

Optional Feature:
Macro: PRF_WR_BYPASS_EN.

Defined:
- A read whose rd_preg matches an enabled same-cycle write (preg != 0) returns that write's wr_data, highest matching port winning.
- rd_ready=1 for that port unless the same preg is also allocated in that cycle without a flush.

Undefined:
- Reads return the pre-edge array contents and ready bits.
- The written value becomes visible the cycle after the edge.

Test Plan:
- Reset then read all pregs: rd_data=0, rd_ready=1, num_busy=0.
- Allocate preg 5 and preg 9 on the two alloc ports -> next cycle rd_ready for 5 and 9 = 0, num_busy=2. Write 0xDEADBEEF to preg 5 -> next cycle rd_data=0xDEADBEEF, rd_ready=1, num_busy=1.
- Same cycle, wr port0 preg 7 = 0x11 and wr port1 preg 7 = 0x22 -> preg 7 reads 0x22. Write to preg 0 with 0xFFFF -> still reads 0, ready 1.
- Bypass: in the same cycle as a write of 0xA5A5A5A5 to preg 12, read preg 12. With PRF_WR_BYPASS_EN -> 0xA5A5A5A5. Without -> old value (0), then 0xA5A5A5A5 the next cycle.
- Allocate preg 20, 21, 22 over two cycles -> num_busy=3. Then flush together with an allocation of preg 23 -> next cycle all ready=1, num_busy=0.
- Assert reset asynchronously between edges after writing preg 3 = 0x1234 and allocating preg 4 -> rd_data for 3 = 0 and rd_ready for 4 = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/phys_reg_file_mp.sv
// Multi-ported physical register file with per-preg ready scoreboard; define PRF_WR_BYPASS_EN for same-cycle write-to-read bypass.
// Reads are combinational (0 cycles), state and num_busy update on the clk edge; no handshake, never stalls.
module phys_reg_file_mp #(
    parameter int DATA_W    = 32,
    parameter int NUM_PREGS = 64,
    parameter int PREG_W    = 6,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_AL    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*PREG_W-1:0]   wr_preg,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_AL-1:0]          al_en,
    input  logic [NUM_AL*PREG_W-1:0]   al_preg,
    input  logic                       flush,
    input  logic [NUM_RD*PREG_W-1:0]   rd_preg,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_ready,
    output logic [PREG_W:0]            num_busy
);

    logic [DATA_W-1:0]    data_q [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready_q;
    logic [NUM_PREGS-1:0] ready_nxt;
    logic [PREG_W:0]      busy_nxt;

    // Ascending port order lets the highest-numbered write port win on a clash.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_preg[k*PREG_W +: PREG_W] != '0)) begin
                    data_q[wr_preg[k*PREG_W +: PREG_W]] <= wr_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Ready priority is applied by overwrite order: write, then allocate, then flush.
    always_comb begin
        ready_nxt = ready_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k]) begin
                ready_nxt[wr_preg[k*PREG_W +: PREG_W]] = 1'b1;
            end
        end
        for (int j = 0; j < NUM_AL; j++) begin
            if (al_en[j]) begin
                ready_nxt[al_preg[j*PREG_W +: PREG_W]] = 1'b0;
            end
        end
        if (flush) begin
            ready_nxt = '1;
        end
        ready_nxt[0] = 1'b1;
    end

    always_comb begin
        busy_nxt = '0;
        for (int i = 0; i < NUM_PREGS; i++) begin
            busy_nxt = busy_nxt + {{PREG_W{1'b0}}, ~ready_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q  <= '1;
            num_busy <= '0;
        end else begin
            ready_q  <= ready_nxt;
            num_busy <= busy_nxt;
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data[r*DATA_W +: DATA_W] = data_q[rd_preg[r*PREG_W +: PREG_W]];
            rd_ready[r]                 = ready_q[rd_preg[r*PREG_W +: PREG_W]];
`ifdef PRF_WR_BYPASS_EN
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_preg[k*PREG_W +: PREG_W] != '0) &&
                    (wr_preg[k*PREG_W +: PREG_W] == rd_preg[r*PREG_W +: PREG_W])) begin
                    rd_data[r*DATA_W +: DATA_W] = wr_data[k*DATA_W +: DATA_W];
                    rd_ready[r]                 = 1'b1;
                end
            end
            // A same-cycle allocation still wins over the bypassed write unless flushed.
            for (int j = 0; j < NUM_AL; j++) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_en[k] && al_en[j] && !flush &&
                        (wr_preg[k*PREG_W +: PREG_W] != '0) &&
                        (wr_preg[k*PREG_W +: PREG_W] == rd_preg[r*PREG_W +: PREG_W]) &&
                        (al_preg[j*PREG_W +: PREG_W] == rd_preg[r*PREG_W +: PREG_W])) begin
                        rd_ready[r] = 1'b0;
                    end
                end
            end
`endif
        end
    end

endmodule
